// File: rtl/logic_unit_pkg.sv
// Shared opcodes and sequencer state encoding for the serial logic datapath.
// Used by the 1-bit gate unit, the word-level sequencer and the bench.
package logic_unit_pkg;

   localparam logic [2:0] SEL_NOT  = 3'b000;
   localparam logic [2:0] SEL_AND  = 3'b001;
   localparam logic [2:0] SEL_NAND = 3'b010;
   localparam logic [2:0] SEL_OR   = 3'b011;
   localparam logic [2:0] SEL_NOR  = 3'b100;
   localparam logic [2:0] SEL_XOR  = 3'b101;
   localparam logic [2:0] SEL_XNOR = 3'b110;
   localparam logic [2:0] SEL_ZERO = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/logic_gate_unit.sv
// Purely combinational 1-bit selectable logic gate with optional B inversion.
// The sequencer streams operand bits through it one pair per cycle.
module logic_gate_unit
   import logic_unit_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [2:0] select,
   input  logic       negate_b,
   output logic       result
);

   logic b_eff;

   assign b_eff = b ^ negate_b;

   // NOT ignores B entirely; the zero opcode falls through to the default.
   always_comb begin
      result = 1'b0;
      case (select)
         SEL_NOT:  result = ~a;
         SEL_AND:  result = a & b_eff;
         SEL_NAND: result = ~(a & b_eff);
         SEL_OR:   result = a | b_eff;
         SEL_NOR:  result = ~(a | b_eff);
         SEL_XOR:  result = a ^ b_eff;
         SEL_XNOR: result = ~(a ^ b_eff);
         default:  result = 1'b0;
      endcase
   end

endmodule

// File: rtl/serial_logic_sequencer.sv
// Word-level front end for the 1-bit gate unit: streams operands LSB-first
// through it and reassembles the returned bits into a result word.
module serial_logic_sequencer
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [2:0]       op_sel,
   input  logic             op_neg_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             gate_a,
   output logic             gate_b,
   output logic [2:0]       gate_select,
   output logic             gate_negate_b,
   input  logic             gate_result
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [2:0]       sel_q, sel_d;
   logic             neg_q, neg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // IDLE and DONE share the accept path, so a start in the DONE cycle
   // chains straight into the next word with no idle gap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      res_d   = res_q;
      sel_d   = sel_q;
      neg_d   = neg_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_SHIFT: begin
            res_d  = {gate_result, res_q[WIDTH-1:1]};
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               busy_d = 1'b1;
            end
         end
         default: begin
            if (start) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               a_sr_d  = op_a;
               b_sr_d  = op_b;
               res_d   = '0;
               sel_d   = op_sel;
               neg_d   = op_neg_b;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         sel_q   <= 3'b000;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         sel_q   <= sel_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign result        = res_q;
   assign gate_a        = a_sr_q[0];
   assign gate_b        = b_sr_q[0];
   assign gate_select   = sel_q;
   assign gate_negate_b = neg_q;

endmodule
